// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin packet bus arbiter.
package bus_arb_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PKT_MAX_W = 64;

  localparam logic [ADDR_W-1:0] BCAST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  // Destination ID sits in the top ADDR_W bits of a width-bit packet.
  function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                  input int unsigned          width);
    return ADDR_W'(pkt >> (width - ADDR_W));
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module bus_rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             valid_c
);

  always_comb begin
    logic [N-1:0] rot;
    int unsigned  cand;
    rot       = '0;
    cand      = 0;
    gnt_idx_c = '0;
    valid_c   = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_i) + i) % N;
      rot  = req_i >> cand;
      if (!valid_c && rot[0]) begin
        valid_c   = 1'b1;
        gnt_idx_c = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin controller for a shared packet bus: pop one packet from the
// granted device, push it to its destination(s), count delivered/dropped.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned       drvrs   = 4,
  parameter int unsigned       pckg_sz = 16,
  parameter logic [ADDR_W-1:0] bcast   = BCAST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [15:0]              pkt_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned IDX_W = $clog2(drvrs);
  localparam int unsigned CNT_W = 16;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0]   gnt_idx_c;
  logic               gnt_valid_c;
  logic [pckg_sz-1:0] head_pkt_c;
  logic [ADDR_W-1:0]  dest_c;
  logic [drvrs-1:0]   self_oh_c;

  bus_rr_pick #(.N(drvrs)) u_pick (
    .req_i     (pndng),
    .last_i    (last_q),
    .gnt_idx_c (gnt_idx_c),
    .valid_c   (gnt_valid_c)
  );

  // In POP, last_q already holds the granted index g.
  assign head_pkt_c = pckg_sz'(D_pop >> (32'(last_q) * pckg_sz));
  assign dest_c     = pkt_dest(PKT_MAX_W'(head_pkt_c), pckg_sz);
  assign self_oh_c  = drvrs'(1) << last_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    pkt_d      = pkt_q;
    pop_d      = '0;
    push_d     = '0;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          last_d  = gnt_idx_c;
          pop_d   = drvrs'(1) << gnt_idx_c;
          state_d = POP;
        end
      end
      POP: begin
        // Decode here so push is registered and valid for the whole PUSH cycle.
        pkt_d   = head_pkt_c;
        state_d = PUSH;
        if (dest_c == bcast) begin
          push_d = ~self_oh_c;
        end else if (32'(dest_c) < drvrs && 32'(dest_c) != 32'(last_q)) begin
          push_d = drvrs'(1) << dest_c;
        end
      end
      PUSH: begin
        state_d = IDLE;
        if (|push_q) pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        else         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(drvrs - 1);
      pkt_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pkt_q      <= pkt_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = pkt_q;
  assign busy     = busy_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (4 devices, 16-bit packets).
module tb_bus_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] d_push;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  logic [15:0] pkts [4];
  int          n_chk;
  int          n_bad;

  bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .bcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (d_push),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pkt(input logic [1:0] dev, input logic [15:0] p);
    pkts[dev] = p;
    d_pop     = {pkts[3], pkts[2], pkts[1], pkts[0]};
  endtask

  // One isolated transfer from dev; called and returns on a negedge with the FSM idle.
  task automatic send(input string tag, input logic [1:0] dev, input logic [15:0] p,
                      input logic [3:0] exp_push);
    set_pkt(dev, p);
    pndng = 4'b0001 << dev;
    @(negedge clk);
    chk({tag, "_pop"}, 32'(pop), 32'(4'b0001 << dev));
    chk({tag, "_pop_push0"}, 32'(push), 32'(0));
    chk({tag, "_busy_pop"}, 32'(busy), 32'(1));
    pndng = '0;
    @(negedge clk);
    chk({tag, "_push"}, 32'(push), 32'(exp_push));
    chk({tag, "_dpush"}, 32'(d_push), 32'(p));
    chk({tag, "_push_pop0"}, 32'(pop), 32'(0));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
    chk({tag, "_idle_push"}, 32'(push), 32'(0));
    chk({tag, "_dpush_hold"}, 32'(d_push), 32'(p));
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    pndng = '0;
    for (int i = 0; i < 4; i++) pkts[i] = '0;
    d_pop = '0;
    repeat (3) @(negedge clk);
    chk("rst_pop", 32'(pop), 32'(0));
    chk("rst_push", 32'(push), 32'(0));
    chk("rst_dpush", 32'(d_push), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pkt", 32'(pkt_cnt), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    send("uni", 2'd1, 16'h02AB, 4'b0100);
    chk("uni_pkt", 32'(pkt_cnt), 32'(1));
    chk("uni_drop", 32'(drop_cnt), 32'(0));

    // Fresh pointer so device 0 gets first grant.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_pkt(2'd0, 16'h01A0);
    set_pkt(2'd1, 16'h02A1);
    set_pkt(2'd2, 16'h03A2);
    set_pkt(2'd3, 16'h00A3);
    pndng = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i % 3 == 0) chk($sformatf("fair_pop%0d", i), 32'(pop), 32'(4'b0001 << (i / 3)));
      else            chk($sformatf("fair_pop%0d", i), 32'(pop), 32'(0));
      if (i % 3 == 1) begin
        chk($sformatf("fair_push%0d", i), 32'(push), 32'(4'b0001 << ((i / 3 + 1) % 4)));
        chk($sformatf("fair_dpush%0d", i), 32'(d_push), 32'(pkts[2'(i / 3)]));
      end else begin
        chk($sformatf("fair_push%0d", i), 32'(push), 32'(0));
      end
      chk($sformatf("fair_busy%0d", i), 32'(busy), 32'(i % 3 != 2));
    end
    pndng = '0;
    chk("fair_pkt", 32'(pkt_cnt), 32'(4));

    send("bc", 2'd3, 16'hFF55, 4'b0111);
    chk("bc_pkt", 32'(pkt_cnt), 32'(5));

    send("self", 2'd2, 16'h0211, 4'b0000);
    send("oor", 2'd2, 16'h0711, 4'b0000);
    chk("drop_cnt", 32'(drop_cnt), 32'(2));
    chk("drop_pkt", 32'(pkt_cnt), 32'(5));

    // Abort a transfer while device 0 is being popped.
    set_pkt(2'd0, 16'h01CC);
    pndng = 4'b0001;
    @(negedge clk);
    chk("mid_pop", 32'(pop), 32'(4'b0001));
    reset = 1'b0;
    pndng = '0;
    #1;
    chk("mid_rst_pop", 32'(pop), 32'(0));
    chk("mid_rst_push", 32'(push), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_dpush", 32'(d_push), 32'(0));
    chk("mid_rst_pkt", 32'(pkt_cnt), 32'(0));
    chk("mid_rst_drop", 32'(drop_cnt), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_push%0d", i), 32'(push), 32'(0));
      chk($sformatf("post_rst_pop%0d", i), 32'(pop), 32'(0));
    end
    pndng = 4'hF;
    @(negedge clk);
    chk("post_rst_first", 32'(pop), 32'(4'b0001));
    pndng = '0;
    @(negedge clk);
    chk("post_rst_push", 32'(push), 32'(4'b0010));
    @(negedge clk);
    chk("post_rst_pkt", 32'(pkt_cnt), 32'(1));

    // Preload the delivered counter near its wrap point.
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    chk("wrap_preload", 32'(pkt_cnt), 32'(16'hFFFE));
    @(negedge clk);
    send("wrap_a", 2'd1, 16'h0322, 4'b1000);
    chk("wrap_ffff", 32'(pkt_cnt), 32'(16'hFFFF));
    send("wrap_b", 2'd2, 16'h0033, 4'b0001);
    chk("wrap_zero", 32'(pkt_cnt), 32'(0));
    chk("wrap_drop", 32'(drop_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin controller for the shared packet bus among `drvrs` FIFO-style devices. It watches every device's `pndng`, grants one device at a time in round-robin order, pops one packet from it, and decodes the destination field. It then pushes the packet to the addressed device, or to every other device for broadcast. It sits between the per-device FIFO ports and the shared `D_push` data bus and also keeps delivered and dropped packet counters.

## Interface
- `drvrs`, 4: number of devices on the bus (2..16).
- `pckg_sz`, 16: packet width in bits (>= 9).
- `bcast`, 8'hFF: destination ID meaning broadcast.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-low.
- `pndng`  in  drvrs: device i has a packet at the head of its FIFO.
- `D_pop`  in  drvrs*pckg_sz: head packet of device i in slice [i*pckg_sz +: pckg_sz].
- `pop`  out  drvrs: one-hot, one-cycle pop strobe to the granted device.
- `push`  out  drvrs: push strobe(s) to the destination device(s).
- `D_push`  out  pckg_sz: shared bus data, valid while any `push` bit is high.
- `busy`  out  1: high in the POP and PUSH states.
- `pkt_cnt`  out  16: packets delivered, wraps at 16'hFFFF -> 0.
- `drop_cnt`  out  16: packets discarded, wraps.

## Operation
- Packet destination field is `pkt[pckg_sz-1 -: 8]`. Remaining bits are payload and pass through untouched.
- The FSM has three states, all outputs registered:
  - **IDLE**: if `|pndng`, pick requester g = first index in order L+1, L+2, …, L+drvrs (mod drvrs) with `pndng[g]=1`. Then set L <= g, assert `pop[g]` next cycle, and go to POP. Otherwise stay.
  - **POP**: `pop[g]`=1 this cycle only. Capture `D_pop[g]` into the packet register at the end of the cycle, regardless of `pndng[g]` in this cycle. Go to PUSH.
  - **PUSH**: `D_push` = captured packet. Destination d is classified as follows:
    - `d == bcast`: `push` = all ones except bit g; `pkt_cnt++`.
    - `d < drvrs` and `d != g`: `push` = one-hot d; `pkt_cnt++`.
    - Otherwise (self-address or out of range): `push` = 0, `drop_cnt++`.
    - Always return to IDLE.
- Round-robin pointer L resets to drvrs-1, so device 0 has first priority after reset.
- Requests arriving during POP/PUSH are only considered in the next IDLE. No request is lost, since `pndng` is level.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, L=drvrs-1, packet register 0. Outputs `pop`=0, `push`=0, `D_push`=0, `busy`=0, `pkt_cnt`=0, `drop_cnt`=0.
- Reset asserted mid-packet: the transfer is abandoned immediately. No pop or push strobe is emitted after release for the abandoned packet.
- Latency: `pndng` high sampled at edge k -> `pop` high in cycle k+1 -> `push`/`D_push` valid in cycle k+2.
- Throughput: one packet per 3 cycles (IDLE, POP, PUSH). `busy` is 0 for at least one cycle between packets.
- `pop` and `push` are never high in the same cycle. `D_push` holds its last value outside PUSH.
- Counters update on the edge ending PUSH.

## Structure
- Package `bus_arb_pkg`:
  - State enum `{IDLE, POP, PUSH}`.
  - `ADDR_W=8`.
  - Default `BCAST` constant.
  - Function to extract the destination from a packet.
- Sub-module `bus_rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and last-grant index.
  - Outputs: grant index and valid.
  - Reusable for other shared resources.
- Top keeps the FSM, packet register, destination decode, and counters.

## Test plan
(drvrs=4, pckg_sz=16)
- **Unicast**: `pndng[1]`=1, `D_pop[1]`=16'h02AB after reset. -> `pop`=4'b0010 at k+1; `push`=4'b0100 and `D_push`=16'h02AB at k+2; `pkt_cnt`=1.
- **Fairness**: all four `pndng` held high for 12 cycles. -> Grants in order 0,1,2,3. Each `pop` is one-hot and spaced 3 cycles apart.
- **Broadcast**: device 3 sends 16'hFF55. -> `push`=4'b0111, `D_push`=16'hFF55, `pkt_cnt` increments by 1.
- **Drops**: device 2 sends 16'h0211 (self-address), then 16'h0711 (out of range). -> `push` stays 0 both times; `drop_cnt`=2; `pkt_cnt` unchanged.
- **Reset mid-packet**: assert reset during POP of device 0, release 2 cycles later with `pndng`=0. -> All outputs 0; no `push` is seen; next request from device 0 is granted first.
- **Counter wrap**: preload via 65536 delivered packets (or force). -> `pkt_cnt` returns to 0 with no effect on `drop_cnt`.
